// File: rtl/seq0110_pkg.sv
// seq0110_pkg: shared state encodings for the 0110 scan arbiter and its detector core.
`default_nettype none
package seq0110_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctl_state_t;

endpackage
`default_nettype wire

// File: rtl/seq0110_core.sv
// seq0110_core: bit-serial Mealy detector for the pattern 0110 (overlaps allowed).
`default_nettype none
module seq0110_core
    import seq0110_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z
);

    det_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q <= S0;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        z       = 1'b0;
        case (state_q)
            S0: state_d = x ? S0 : S1;
            S1: state_d = x ? S2 : S1;
            S2: state_d = x ? S3 : S1;
            S3: begin
                state_d = x ? S0 : S1;
                z       = en && !x;
            end
            default: state_d = S0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq0110_scan_arbiter.sv
// seq0110_scan_arbiter: round-robin share of one 0110 detector between two word producers;
// each granted word is shifted MSB-first and its match count returned with the requester ID.
`default_nettype none
module seq0110_scan_arbiter
    import seq0110_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    input  logic [2*W-1:0]  req_data,
    output logic [1:0]      req_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [CW-1:0]   rsp_count,
    output logic            rsp_hit,
    output logic            busy
);

    localparam int IW = $clog2(W);

    ctl_state_t     state_q, state_d;
    logic           rr_q, rr_d;
    logic [W-1:0]   word_q, word_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  count_q, count_d;
    logic           rsp_id_q, rsp_id_d;
    logic [CW-1:0]  rsp_count_q, rsp_count_d;
    logic           rsp_hit_q, rsp_hit_d;

    logic           gnt_id;
    logic           det_clr, det_en, det_x, det_z;
    logic [CW-1:0]  count_inc;

    seq0110_core u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .en    (det_en),
        .x     (det_x),
        .z     (det_z)
    );

    // Pointer owner wins if it is asking; otherwise the other requester may take the slot.
    assign gnt_id    = req_valid[rr_q] ? rr_q : ~rr_q;
    assign count_inc = (det_z && (count_q != {CW{1'b1}})) ? count_q + CW'(1) : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            word_q      <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            rsp_id_q    <= 1'b0;
            rsp_count_q <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
            rsp_hit_q   <= rsp_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        word_d      = word_q;
        idx_d       = idx_q;
        count_d     = count_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;
        rsp_hit_d   = rsp_hit_q;
        req_ready   = 2'b00;
        det_clr     = 1'b0;
        det_en      = 1'b0;
        det_x       = word_q[idx_q];
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[gnt_id] = 1'b1;
                    word_d   = gnt_id ? req_data[2*W-1:W] : req_data[W-1:0];
                    rsp_id_d = gnt_id;
                    idx_d    = IW'(W - 1);
                    count_d  = '0;
                    det_clr  = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                det_en  = 1'b1;
                count_d = count_inc;
                if (idx_q == '0) begin
                    rsp_count_d = count_inc;
                    rsp_hit_d   = (count_inc != '0);
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rr_d    = ~rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_count_q;
    assign rsp_hit   = rsp_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_seq0110_scan_arbiter.sv
// tb_seq0110_scan_arbiter: directed self-checking bench for the 0110 scan arbiter (W=8).
`default_nettype none
module tb_seq0110_scan_arbiter;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic [1:0]     req_valid = 2'b00;
    logic [2*W-1:0] req_data  = '0;
    logic [1:0]     req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_id;
    logic [CW-1:0]  rsp_count;
    logic           rsp_hit;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq0110_scan_arbiter #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_hit   (rsp_hit),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input int r, input logic [W-1:0] d);
        req_data[r*W +: W] = d;
        req_valid[r]       = 1'b1;
    endtask

    // Waits for a grant, checks it, then follows the word to its result. Returns in the first DONE cycle.
    task automatic expect_word(input int id, input int cnt, input bit drop);
        int n;
        int lat;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(req_ready), 32'(1) << id);
        @(negedge clk);
        if (drop) req_valid[id] = 1'b0;
        chk("busy", 32'(busy), 32'd1);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, W + 1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_count", 32'(rsp_count), 32'(cnt));
        chk("rsp_hit", 32'(rsp_hit), 32'(cnt != 0));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(rsp_count), 32'd0);
        chk("rst_hit", 32'(rsp_hit), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;

        // Basic word, overlapping matches, no matches
        put(0, 8'b0110_0110); expect_word(0, 2, 1); @(negedge clk);
        put(1, 8'b0110_1101); expect_word(1, 2, 1); @(negedge clk);
        put(1, 8'hFF);        expect_word(1, 0, 1); @(negedge clk);

        // Round robin with both requesters continuously valid (0x36 = 0011_0110 has two overlapping hits)
        put(0, 8'h36); put(1, 8'h66);
        expect_word(0, 2, 0); @(negedge clk);
        expect_word(1, 2, 0); @(negedge clk);
        expect_word(0, 2, 0); @(negedge clk);
        expect_word(1, 2, 0);
        req_valid = 2'b00;
        @(negedge clk);

        // Backpressure in DONE with the other requester waiting
        rsp_ready = 1'b0;
        put(0, 8'h66); put(1, 8'h36);
        expect_word(0, 2, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_count", 32'(rsp_count), 32'd2);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        expect_word(1, 2, 1); @(negedge clk);

        // Reset during the fourth SHIFT cycle of a req1 word
        put(1, 8'hFF);
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("abort_grant", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("ar_valid", 32'(rsp_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_id", 32'(rsp_id), 32'd0);
        chk("ar_count", 32'(rsp_count), 32'd0);
        chk("ar_hit", 32'(rsp_hit), 32'd0);
        chk("ar_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        put(0, 8'b0000_0110); expect_word(0, 1, 1); @(negedge clk);

        // Detector state must not carry across the word boundary
        put(0, 8'b0000_0011); expect_word(0, 0, 1); @(negedge clk);
        put(0, 8'b0110_0000); expect_word(0, 1, 1); @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
